// File: rtl/shot_clock_timer.sv
// ---------------------------------------------------------------------------
// shot_clock_timer
//
// Countdown shot clock for the scoreboard. Holds a packed multi-digit BCD
// count that decrements once per second (derived from clk by an internal
// prescaler), with a run/pause/expired state machine, a full reload, a short
// "raise-to-N-if-lower" reload, a low-time warning flag and an optional expiry
// buzzer. Feeds the existing BCD-to-7-segment display drivers directly.
//
// Optional feature macro: SHOT_CLOCK_BUZZER_EN
//   defined   -> buzz pulses for BUZZ_SEC seconds when the clock expires
//   undefined -> buzz is tied low and no buzzer counter is built
//
// Parameters:
//   DIGITS     number of BCD digits (value width 4*DIGITS)
//   TICK_DIV   clk cycles per one-second tick (>= 2)
//   FULL_BCD   full reload value, packed BCD, nonzero
//   SHORT_BCD  short reload value, packed BCD, <= FULL_BCD
//   WARN_BCD   warning threshold, packed BCD
//   BUZZ_SEC   buzzer duration in seconds (buzzer build only)
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   start         in   strobe: start, resume, or restart after expiry
//   pause         in   strobe: toggle RUN/PAUSE
//   reload        in   strobe: load FULL_BCD
//   reload_short  in   strobe: raise value to SHORT_BCD if below it
//   value_bcd     out  current count, packed BCD, MS digit on top
//   sec_tick      out  one-cycle pulse on each decrement
//   running       out  high in RUN
//   warn          out  high in RUN/PAUSE with 0 < value <= WARN_BCD
//   expired       out  high in EXPIRED
//   buzz          out  expiry buzzer drive
// ---------------------------------------------------------------------------
module shot_clock_timer #(
  parameter int DIGITS = 2,
  parameter int TICK_DIV = 50_000_000,
  parameter logic [4*DIGITS-1:0] FULL_BCD = 'h24,
  parameter logic [4*DIGITS-1:0] SHORT_BCD = 'h14,
  parameter logic [4*DIGITS-1:0] WARN_BCD = 'h05,
  parameter int BUZZ_SEC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  reload,
  input  logic                  reload_short,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic                  sec_tick,
  output logic                  running,
  output logic                  warn,
  output logic                  expired,
  output logic                  buzz
);

  localparam int VW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [VW-1:0] ONE = VW'(1);

  // Elaboration-time sanity check of the configuration.
  if (TICK_DIV < 2 || BUZZ_SEC < 0) begin : g_bad_cfg
    $error("shot_clock_timer: TICK_DIV must be >= 2 and BUZZ_SEC >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [VW-1:0]   value_n;
  logic [PW-1:0]   presc, presc_n, presc_inc;
  logic            at_wrap;
  logic            tick_n;
  logic            running_n, warn_n, expired_n;

  // Decrement a packed BCD word by one. A zero digit becomes 9 and the
  // borrow ripples into the next digit up. Callers never pass zero.
  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          borrow;
    r = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // State, count, prescaler and all flag outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      value_bcd <= FULL_BCD;
      presc     <= '0;
      sec_tick  <= 1'b0;
      running   <= 1'b0;
      warn      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_n;
      value_bcd <= value_n;
      presc     <= presc_n;
      sec_tick  <= tick_n;
      running   <= running_n;
      warn      <= warn_n;
      expired   <= expired_n;
    end
  end

  // Next-state logic. Strobes are resolved in priority order
  // reload > reload_short > start > pause; only one of them acts.
  // A start seen in RUN is ignored but still masks pause. The tick is
  // suppressed by either reload, but not by pause, so a pause landing on
  // the tick still decrements (and expiry beats the pause).
  always_comb begin
    state_n   = state;
    value_n   = value_bcd;
    presc_n   = presc;
    tick_n    = 1'b0;
    at_wrap   = (presc == PRE_MAX);
    presc_inc = at_wrap ? '0 : presc + 1'b1;

    if (reload || reload_short) begin
      if (reload) begin
        value_n = FULL_BCD;
        presc_n = '0;
      end else if (value_bcd < SHORT_BCD) begin
        value_n = SHORT_BCD;
        presc_n = '0;
      end else if (state == S_RUN) begin
        // No raise needed: the second keeps running, but this cycle
        // cannot produce a decrement.
        presc_n = presc_inc;
      end
      if (state != S_RUN && state != S_PAUSE) begin
        state_n = S_IDLE;
      end
    end else if (start && state != S_RUN) begin
      if (state == S_EXPIRED) begin
        value_n = FULL_BCD;
        presc_n = '0;
      end
      state_n = S_RUN;
    end else if (state == S_RUN) begin
      presc_n = presc_inc;
      if (pause && !start) begin
        state_n = S_PAUSE;
      end
      if (at_wrap) begin
        tick_n = 1'b1;
        if (value_bcd <= ONE) begin
          value_n = '0;
          state_n = S_EXPIRED;
        end else begin
          value_n = bcd_dec(value_bcd);
        end
      end
    end else if (state == S_PAUSE && pause) begin
      state_n = S_RUN;
    end

    // The prescaler only carries a partial second through RUN/PAUSE.
    if (state_n == S_IDLE || state_n == S_EXPIRED) begin
      presc_n = '0;
    end

    running_n = (state_n == S_RUN);
    expired_n = (state_n == S_EXPIRED);
    warn_n    = (state_n == S_RUN || state_n == S_PAUSE) &&
                (value_n != '0) && (value_n <= WARN_BCD);
  end

`ifdef SHOT_CLOCK_BUZZER_EN
  localparam int BUZZ_LEN = BUZZ_SEC * TICK_DIV;
  localparam int BW = (BUZZ_LEN < 2) ? 1 : $clog2(BUZZ_LEN);

  if (BUZZ_SEC < 1) begin : g_bad_buzz
    $error("shot_clock_timer: BUZZ_SEC must be >= 1 in the buzzer build");
  end

  logic [BW-1:0] buzz_cnt, buzz_cnt_n;
  logic          buzz_n;

  // The buzzer counter is loaded on the cycle the state enters EXPIRED and
  // counts down while we stay there; leaving EXPIRED for any reason
  // (reload, reload_short, start, rst) silences it at once.
  always_comb begin
    buzz_n     = 1'b0;
    buzz_cnt_n = '0;
    if (state_n == S_EXPIRED) begin
      if (state != S_EXPIRED) begin
        buzz_n     = 1'b1;
        buzz_cnt_n = BW'(BUZZ_LEN - 1);
      end else if (buzz && buzz_cnt != '0) begin
        buzz_n     = 1'b1;
        buzz_cnt_n = buzz_cnt - 1'b1;
      end
    end
  end

  // Buzzer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buzz     <= 1'b0;
      buzz_cnt <= '0;
    end else begin
      buzz     <= buzz_n;
      buzz_cnt <= buzz_cnt_n;
    end
  end
`else
  assign buzz = 1'b0;
`endif

endmodule

// File: tb/tb_shot_clock_timer.sv
// ---------------------------------------------------------------------------
// tb_shot_clock_timer
//
// Self-checking bench for shot_clock_timer. Two instances run side by side:
//   dut1: DIGITS=2, TICK_DIV=4, default reload values
//   dut2: DIGITS=3, TICK_DIV=4, FULL_BCD='h100
// Every cycle the stimulus is fed to a behavioural model that keeps the
// count as a plain integer; the predicted outputs are queued and compared
// against the DUT one clock later.
// ---------------------------------------------------------------------------
module tb_shot_clock_timer;

  localparam int TDIV = 4;
`ifdef SHOT_CLOCK_BUZZER_EN
  localparam int BUZZ_LEN = 3 * TDIV;
`else
  localparam int BUZZ_LEN = 0;
`endif

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_EXP  = 3;

  // Stimulus bit positions: {rst, reload, reload_short, start, pause}
  localparam logic [4:0] NONE   = 5'b00000;
  localparam logic [4:0] RST    = 5'b10000;
  localparam logic [4:0] RELOAD = 5'b01000;
  localparam logic [4:0] RSHORT = 5'b00100;
  localparam logic [4:0] START  = 5'b00010;
  localparam logic [4:0] PAUSE  = 5'b00001;

  typedef struct packed {
    int st;
    int val;
    int pre;
    int bcnt;
    bit tick;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, start1, pause1, reload1, rshort1;
  logic rst2, start2, pause2, reload2, rshort2;
  logic [7:0]  value1;
  logic [11:0] value2;
  logic tick1, run1, warn1, exp1, buzz1;
  logic tick2, run2, warn2, exp2, buzz2;

  int vectors = 0;
  int miscompares = 0;

  model_t m1, m2;
  model_t q1[$];
  model_t q2[$];

  shot_clock_timer #(
    .DIGITS(2), .TICK_DIV(TDIV)
  ) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .pause(pause1),
    .reload(reload1), .reload_short(rshort1),
    .value_bcd(value1), .sec_tick(tick1), .running(run1),
    .warn(warn1), .expired(exp1), .buzz(buzz1)
  );

  shot_clock_timer #(
    .DIGITS(3), .TICK_DIV(TDIV),
    .FULL_BCD(12'h100), .SHORT_BCD(12'h014), .WARN_BCD(12'h005)
  ) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .pause(pause2),
    .reload(reload2), .reload_short(rshort2),
    .value_bcd(value2), .sec_tick(tick2), .running(run2),
    .warn(warn2), .expired(exp2), .buzz(buzz2)
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // One clock of reference behaviour; the count is kept in decimal.
  function automatic model_t model_step(input model_t m, input logic [4:0] s,
                                        input int full, input int short_v);
    model_t r;
    r = m;
    r.tick = 1'b0;
    if (s[4]) begin
      r.st = ST_IDLE; r.val = full; r.pre = 0; r.bcnt = 0;
      return r;
    end
    if (s[3] || s[2]) begin
      if (s[3]) begin
        r.val = full; r.pre = 0;
      end else if (m.val < short_v) begin
        r.val = short_v; r.pre = 0;
      end else if (m.st == ST_RUN) begin
        r.pre = (m.pre + 1) % TDIV;
      end
      if (m.st == ST_IDLE || m.st == ST_EXP) r.st = ST_IDLE;
    end else if (s[1] && m.st != ST_RUN) begin
      if (m.st == ST_EXP) begin
        r.val = full; r.pre = 0;
      end
      r.st = ST_RUN;
    end else if (m.st == ST_RUN) begin
      if (m.pre == TDIV - 1) begin
        r.pre = 0;
        r.tick = 1'b1;
        r.val = (m.val > 0) ? m.val - 1 : 0;
      end else begin
        r.pre = m.pre + 1;
      end
      if (s[0] && !s[1]) r.st = ST_PAUSE;
      if (r.tick && r.val == 0) r.st = ST_EXP;
    end else if (m.st == ST_PAUSE && s[0]) begin
      r.st = ST_RUN;
    end
    if (r.st == ST_EXP && m.st != ST_EXP) r.bcnt = BUZZ_LEN;
    else if (r.st == ST_EXP) r.bcnt = (m.bcnt > 0) ? m.bcnt - 1 : 0;
    else r.bcnt = 0;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_dut(input string name, input model_t e,
                             input logic [11:0] v, input logic t,
                             input logic r, input logic w,
                             input logic ex, input logic b);
    logic exp_warn;
    exp_warn = (e.st == ST_RUN || e.st == ST_PAUSE) && e.val > 0 && e.val <= 5;
    checkOutput({name, ".value"},    32'(v),  32'(to_bcd(e.val)));
    checkOutput({name, ".sec_tick"}, 32'(t),  32'(e.tick));
    checkOutput({name, ".running"},  32'(r),  32'(e.st == ST_RUN));
    checkOutput({name, ".warn"},     32'(w),  32'(exp_warn));
    checkOutput({name, ".expired"},  32'(ex), 32'(e.st == ST_EXP));
    checkOutput({name, ".buzz"},     32'(b),  32'(e.bcnt > 0));
  endtask

  // Drive one cycle of strobes, queue the prediction, then check it.
  task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2);
    model_t e1, e2;
    @(negedge clk);
    {rst1, reload1, rshort1, start1, pause1} = s1;
    {rst2, reload2, rshort2, start2, pause2} = s2;
    m1 = model_step(m1, s1, 24, 14);
    m2 = model_step(m2, s2, 100, 14);
    q1.push_back(m1);
    q2.push_back(m2);
    @(posedge clk);
    #1;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    compare_dut("dut1", e1, {4'h0, value1}, tick1, run1, warn1, exp1, buzz1);
    compare_dut("dut2", e2, value2, tick2, run2, warn2, exp2, buzz2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(NONE, NONE);
  endtask

  task automatic run_until(input int v);
    int n;
    n = 0;
    while (m1.val != v && n < 300) begin
      applyStimulus(NONE, NONE);
      n++;
    end
    if (n >= 300) checkOutput("run_until_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_pre(input int p);
    int n;
    n = 0;
    while (m1.pre != p && n < 2 * TDIV) begin
      applyStimulus(NONE, NONE);
      n++;
    end
    if (n >= 2 * TDIV) checkOutput("wait_pre_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    m1 = '0;
    m2 = '0;
    {rst1, reload1, rshort1, start1, pause1} = RST;
    {rst2, reload2, rshort2, start2, pause2} = RST;

    // Reset, then a full uninterrupted run to expiry.
    applyStimulus(RST, RST);
    applyStimulus(RST, RST);
    idle(2);
    applyStimulus(START, START);
    idle(98);

    // reload together with start while expired (buzzer still active).
    applyStimulus(RELOAD | START, NONE);
    idle(2);

    // Pause at 11 mid-second, hold, then resume.
    applyStimulus(START, NONE);
    run_until(11);
    idle(2);
    applyStimulus(PAUSE, NONE);
    idle(10);
    applyStimulus(PAUSE, NONE);

    // Short reload raising 09 to 14, and a full reload while running.
    run_until(9);
    applyStimulus(RSHORT, NONE);
    run_until(12);
    applyStimulus(RELOAD, NONE);

    // Short reload that must leave 18 alone.
    run_until(18);
    idle(1);
    applyStimulus(RSHORT, NONE);

    // Pause landing exactly on a tick, then resume with start.
    wait_pre(TDIV - 1);
    applyStimulus(PAUSE, NONE);
    idle(3);
    applyStimulus(START, NONE);

    // Pause on the final tick: expiry wins, then the buzzer runs out.
    run_until(1);
    wait_pre(TDIV - 1);
    applyStimulus(PAUSE, NONE);
    idle(16);

    // start while expired restarts from the full value.
    applyStimulus(START, NONE);

    // rst coinciding with a tick at 07.
    run_until(7);
    wait_pre(TDIV - 1);
    applyStimulus(RST, NONE);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
